// File: rtl/hazard_unit.sv
// Pipeline hazard/redirect control: per-stage stall and flush, PC source select,
// and a small busy tracker for the multi-cycle mult/div unit.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | mult/div unit free; a MULT/DIV in EX starts it
//   S_BUSY | unit occupied, md_cnt_q counts down remaining busy cycles
module hazard_unit #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 33
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs_addr,
   input  logic [4:0]  id_rt_addr,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic [3:0]  id_md_op,
   input  logic        idex_mem_r,
   input  logic [4:0]  idex_rt_addr,
   input  logic [3:0]  idex_md_op,
   input  logic        ex_nop,
   input  logic        ex_redirect,
   input  logic        mem_exc_req,
   input  logic        mem_eret,
   output logic        pc_stall,
   output logic [1:0]  pc_sel,
   output logic        ifid_stall,
   output logic        ifid_flush,
   output logic        cu_stall,
   output logic        cu_flush,
   output logic        exmem_flush,
   output logic        md_busy,
   output logic [31:0] stall_count
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } md_state_t;

   localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
   localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

   md_state_t   state_q, state_d;
   logic [7:0]  md_cnt_q, md_cnt_d;
   logic [31:0] stall_count_q, stall_count_d;

   logic md_start;
   logic md_is_mul;
   logic md_abort;
   logic busy;
   logic id_md_any;
   logic md_hazard;
   logic load_use;
   logic id_hold;

   assign md_start  = !ex_nop && (idex_md_op >= 4'd1) && (idex_md_op <= 4'd4);
   assign md_is_mul = (idex_md_op == 4'd1) || (idex_md_op == 4'd2);
   assign md_abort  = mem_exc_req || mem_eret;

   // Reset masks the registered state so outputs look IDLE while reset is held.
   assign busy      = !reset && (state_q == S_BUSY);
   assign id_md_any = (id_md_op >= 4'd1) && (id_md_op <= 4'd8);
   assign md_hazard = (busy || md_start) && id_md_any;

   assign load_use = idex_mem_r && (idex_rt_addr != 5'd0) &&
                     ((id_uses_rs && (id_rs_addr == idex_rt_addr)) ||
                      (id_uses_rt && (id_rt_addr == idex_rt_addr)));

   assign id_hold = load_use || md_hazard;

   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (md_start && !md_abort) begin
               state_d  = S_BUSY;
               md_cnt_d = md_is_mul ? MUL_LOAD : DIV_LOAD;
            end
         end
         S_BUSY: begin
            if (md_abort || (md_cnt_q == 8'd0)) begin
               state_d  = S_IDLE;
               md_cnt_d = 8'd0;
            end else begin
               md_cnt_d = md_cnt_q - 8'd1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            md_cnt_d = 8'd0;
         end
      endcase
   end

   always_comb begin
      pc_stall    = 1'b0;
      pc_sel      = 2'b00;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      cu_stall    = 1'b0;
      cu_flush    = 1'b0;
      exmem_flush = 1'b0;
      if (mem_exc_req) begin
         pc_sel      = 2'b10;
         ifid_flush  = 1'b1;
         cu_flush    = 1'b1;
         exmem_flush = 1'b1;
      end else if (mem_eret) begin
         pc_sel      = 2'b11;
         ifid_flush  = 1'b1;
         cu_flush    = 1'b1;
         exmem_flush = 1'b1;
      end else if (id_hold) begin
         ifid_stall = 1'b1;
         cu_flush   = 1'b1;
         // A redirect still lets the PC take the target; the delay slot waits in IF/ID.
         if (ex_redirect) begin
            pc_sel = 2'b01;
         end else begin
            pc_stall = 1'b1;
         end
      end else if (ex_redirect) begin
         pc_sel     = 2'b01;
         ifid_flush = 1'b1;
      end
   end

   assign stall_count_d = stall_count_q + {31'd0, ifid_stall};

   // Same edge as the pipeline registers.
   always_ff @(negedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         md_cnt_q      <= 8'd0;
         stall_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         md_cnt_q      <= md_cnt_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign md_busy     = busy;
   assign stall_count = reset ? 32'd0 : stall_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: load-use, mult/div busy, redirects,
// exception/eret priority, reset while busy and stall counter wrap.
module tb_hazard_unit;

   logic        clk;
   logic        reset;
   logic [4:0]  id_rs_addr;
   logic [4:0]  id_rt_addr;
   logic        id_uses_rs;
   logic        id_uses_rt;
   logic [3:0]  id_md_op;
   logic        idex_mem_r;
   logic [4:0]  idex_rt_addr;
   logic [3:0]  idex_md_op;
   logic        ex_nop;
   logic        ex_redirect;
   logic        mem_exc_req;
   logic        mem_eret;
   logic        pc_stall;
   logic [1:0]  pc_sel;
   logic        ifid_stall;
   logic        ifid_flush;
   logic        cu_stall;
   logic        cu_flush;
   logic        exmem_flush;
   logic        md_busy;
   logic [31:0] stall_count;

   int n_checks = 0;
   int n_errors = 0;

   hazard_unit #(.MUL_CYCLES(5), .DIV_CYCLES(33)) dut (
      .clk          (clk),
      .reset        (reset),
      .id_rs_addr   (id_rs_addr),
      .id_rt_addr   (id_rt_addr),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .id_md_op     (id_md_op),
      .idex_mem_r   (idex_mem_r),
      .idex_rt_addr (idex_rt_addr),
      .idex_md_op   (idex_md_op),
      .ex_nop       (ex_nop),
      .ex_redirect  (ex_redirect),
      .mem_exc_req  (mem_exc_req),
      .mem_eret     (mem_eret),
      .pc_stall     (pc_stall),
      .pc_sel       (pc_sel),
      .ifid_stall   (ifid_stall),
      .ifid_flush   (ifid_flush),
      .cu_stall     (cu_stall),
      .cu_flush     (cu_flush),
      .exmem_flush  (exmem_flush),
      .md_busy      (md_busy),
      .stall_count  (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance past the active (negative) edge; inputs change and outputs are checked mid-cycle.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_rs_addr   = 5'd0;
      id_rt_addr   = 5'd0;
      id_uses_rs   = 1'b0;
      id_uses_rt   = 1'b0;
      id_md_op     = 4'd0;
      idex_mem_r   = 1'b0;
      idex_rt_addr = 5'd0;
      idex_md_op   = 4'd0;
      ex_nop       = 1'b1;
      ex_redirect  = 1'b0;
      mem_exc_req  = 1'b0;
      mem_eret     = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   // Control outputs packed {pc_stall, pc_sel, ifid_stall, ifid_flush, cu_stall, cu_flush, exmem_flush}
   function automatic logic [31:0] ctl();
      return {24'd0, pc_stall, pc_sel, ifid_stall, ifid_flush, cu_stall, cu_flush, exmem_flush};
   endfunction

   function automatic logic [31:0] mk(input logic ps, input logic [1:0] sel, input logic is_,
                                      input logic if_, input logic cs, input logic cf, input logic ef);
      return {24'd0, ps, sel, is_, if_, cs, cf, ef};
   endfunction

   initial begin
      int n;
      clear_inputs();
      reset = 1'b1;
      #1;
      chk("reset_busy_comb", {31'd0, md_busy}, 32'd0);
      tick();
      chk("reset_busy", {31'd0, md_busy}, 32'd0);
      chk("reset_count", stall_count, 32'd0);
      chk("reset_ctl", ctl(), mk(0, 2'b00, 0, 0, 0, 0, 0));
      reset = 1'b0;
      #1;

      // Load-use on rs
      idex_mem_r = 1'b1; idex_rt_addr = 5'd5; ex_nop = 1'b0;
      id_rs_addr = 5'd5; id_uses_rs = 1'b1; id_rt_addr = 5'd1; id_uses_rt = 1'b1;
      #1;
      chk("lu_rs_ctl", ctl(), mk(1, 2'b00, 1, 0, 0, 1, 0));
      tick();
      chk("lu_rs_count", stall_count, 32'd1);
      // Bubble behind the load: hazard gone
      idex_mem_r = 1'b0; ex_nop = 1'b1;
      #1;
      chk("lu_released", ctl(), mk(0, 2'b00, 0, 0, 0, 0, 0));
      // Load into r0 never stalls
      idex_mem_r = 1'b1; idex_rt_addr = 5'd0; ex_nop = 1'b0; id_rs_addr = 5'd0;
      #1;
      chk("lu_r0", ctl(), mk(0, 2'b00, 0, 0, 0, 0, 0));
      // rt match, then same addresses with uses_rt clear
      idex_rt_addr = 5'd7; id_rs_addr = 5'd2; id_rt_addr = 5'd7;
      #1;
      chk("lu_rt", {31'd0, ifid_stall}, 32'd1);
      id_uses_rt = 1'b0;
      #1;
      chk("lu_rt_unused", {31'd0, ifid_stall}, 32'd0);
      tick();
      chk("lu_count_after", stall_count, 32'd1);

      // MULT: 5 busy cycles, MFLO held for exactly those
      clear_inputs();
      do_reset();
      idex_md_op = 4'd1; ex_nop = 1'b0;
      #1;
      chk("mult_start_nostall", {31'd0, ifid_stall}, 32'd0);
      tick();
      idex_md_op = 4'd0; ex_nop = 1'b1; id_md_op = 4'd6;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("mult_busy_%0d", i), {30'd0, md_busy, ifid_stall}, 32'd3);
         tick();
      end
      #1;
      chk("mult_done", {30'd0, md_busy, ifid_stall}, 32'd0);
      chk("mult_count", stall_count, 32'd5);

      // md_start itself is a hazard for an md op in ID
      clear_inputs();
      idex_md_op = 4'd3; ex_nop = 1'b0; id_md_op = 4'd7;
      #1;
      chk("div_start_hazard", ctl(), mk(1, 2'b00, 1, 0, 0, 1, 0));
      tick();
      idex_md_op = 4'd0; ex_nop = 1'b1; id_md_op = 4'd0;
      tick();
      tick();
      chk("div_busy_pre_exc", {31'd0, md_busy}, 32'd1);
      mem_exc_req = 1'b1; id_md_op = 4'd5;
      #1;
      chk("exc_ctl", ctl(), mk(0, 2'b10, 0, 1, 0, 1, 1));
      tick();
      mem_exc_req = 1'b0; id_md_op = 4'd0;
      #1;
      chk("exc_abort_busy", {31'd0, md_busy}, 32'd0);

      // Start suppressed by a concurrent exception
      idex_md_op = 4'd4; ex_nop = 1'b0; mem_exc_req = 1'b1;
      tick();
      clear_inputs();
      #1;
      chk("exc_blocks_start", {31'd0, md_busy}, 32'd0);

      // Full DIV duration
      idex_md_op = 4'd4; ex_nop = 1'b0;
      tick();
      clear_inputs();
      n = 0;
      while (md_busy && n < 100) begin
         n++;
         tick();
      end
      chk("div_cycles", n, 32'd33);

      // Redirects
      clear_inputs();
      ex_redirect = 1'b1;
      #1;
      chk("redir_only", ctl(), mk(0, 2'b01, 0, 1, 0, 0, 0));
      idex_mem_r = 1'b1; idex_rt_addr = 5'd9; ex_nop = 1'b0; id_rt_addr = 5'd9; id_uses_rt = 1'b1;
      #1;
      chk("redir_lu", ctl(), mk(0, 2'b01, 1, 0, 0, 1, 0));

      // Exception vs eret priority
      clear_inputs();
      mem_exc_req = 1'b1; mem_eret = 1'b1;
      #1;
      chk("exc_eret_both", ctl(), mk(0, 2'b10, 0, 1, 0, 1, 1));
      mem_exc_req = 1'b0; ex_redirect = 1'b1;
      #1;
      chk("eret_only", ctl(), mk(0, 2'b11, 0, 1, 0, 1, 1));

      // Reset while busy with md_cnt at 20
      clear_inputs();
      do_reset();
      idex_md_op = 4'd3; ex_nop = 1'b0;
      tick();
      clear_inputs();
      id_md_op = 4'd5;
      for (int i = 0; i < 12; i++) tick();
      chk("pre_reset_state", {stall_count[30:0], md_busy}, {31'd12, 1'b1});
      reset = 1'b1;
      #1;
      chk("reset_mask_busy", {31'd0, md_busy}, 32'd0);
      tick();
      reset = 1'b0; id_md_op = 4'd0;
      #1;
      chk("reset_busy_after", {31'd0, md_busy}, 32'd0);
      chk("reset_count_after", stall_count, 32'd0);
      tick();
      chk("reset_stays_idle", {31'd0, md_busy}, 32'd0);

      // Counter wrap
      force dut.stall_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_count_q;
      #1;
      chk("wrap_preset", stall_count, 32'hFFFF_FFFF);
      idex_mem_r = 1'b1; idex_rt_addr = 5'd3; ex_nop = 1'b0; id_rs_addr = 5'd3; id_uses_rs = 1'b1;
      tick();
      clear_inputs();
      #1;
      chk("wrap_zero", stall_count, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
